// File: rtl/gfx_rom_pkg.sv
// Shared types and constants for the graphics ROM SDRAM arbiter.
// Region bases map each client's word address into SDRAM.
package gfx_rom_pkg;

    localparam int CLI_BACK1 = 0;
    localparam int CLI_BACK2 = 1;
    localparam int CLI_SPR   = 2;

    localparam logic [23:0] REGION_BASE [3] = '{
        24'h020000,
        24'h030000,
        24'h040000
    };

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } arb_state_t;

    function automatic logic [23:0] region_base(input logic [1:0] idx);
        logic [23:0] base;
        case (idx)
            2'd0:    base = REGION_BASE[CLI_BACK1];
            2'd1:    base = REGION_BASE[CLI_BACK2];
            2'd2:    base = REGION_BASE[CLI_SPR];
            default: base = '0;
        endcase
        return base;
    endfunction

endpackage

// File: rtl/gfx_rom_sdram_arbiter_rr_pick.sv
// Round-robin pick: first pending index at or after ptr, cyclic.
// Purely combinational; ptr is assumed to be below N.
module rr_priority_pick
    import gfx_rom_pkg::*;
#(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  pend,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    function automatic logic [IW-1:0] wrap(
        input logic [IW-1:0] p,
        input int            k
    );
        int s;
        s = int'(p) + k;
        if (s >= N) s = s - N;
        return IW'(s);
    endfunction

    logic [IW-1:0] cand;
    logic          found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            cand = wrap(ptr, k);
            if (!found && pend[cand]) begin
                found     = 1'b1;
                idx       = cand;
                gnt[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gfx_rom_sdram_arbiter.sv
// Shares one SDRAM read port among toggle-handshake graphics clients,
// refetching when a client's address moves while its read is in flight.
module gfx_rom_sdram_arbiter
    import gfx_rom_pkg::*;
#(
    parameter int NUM_CLIENTS = 3,
    parameter int CLI_AW      = 24,
    parameter int MAX_REFETCH = 3
) (
    input  logic                          clk,
    input  logic                          RESET,
    input  logic [NUM_CLIENTS*CLI_AW-1:0] cli_addr,
    input  logic [NUM_CLIENTS-1:0]        cli_req,
    output logic [NUM_CLIENTS-1:0]        cli_ack,
    output logic [NUM_CLIENTS*16-1:0]     cli_data,
    output logic [23:0]                   sd_addr,
    output logic                          sd_rd,
    input  logic                          sd_rdy,
    input  logic [15:0]                   sd_data,
    input  logic                          sd_valid,
    output logic                          busy
);

    localparam int IW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam int CW = $clog2(MAX_REFETCH + 1);

    arb_state_t              state_q, state_d;
    logic [IW-1:0]           rr_q, rr_d;
    logic [IW-1:0]           g_q, g_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [CLI_AW-1:0]       cap_q, cap_d;
    logic [23:0]             sd_addr_q, sd_addr_d;
    logic                    sd_rd_q, sd_rd_d;
    logic [NUM_CLIENTS-1:0]  ack_q, ack_d;
    logic [15:0]             data_q [NUM_CLIENTS];
    logic [15:0]             data_d [NUM_CLIENTS];

    logic [CLI_AW-1:0]       addr_arr [NUM_CLIENTS];
    logic [NUM_CLIENTS-1:0]  pick_gnt;
    logic [IW-1:0]           pick_idx;

    for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_cli
        assign addr_arr[i]        = cli_addr[i*CLI_AW +: CLI_AW];
        assign cli_data[i*16 +: 16] = data_q[i];
    end

    rr_priority_pick #(
        .N  (NUM_CLIENTS),
        .IW (IW)
    ) u_pick (
        .pend (cli_req ^ ack_q),
        .ptr  (rr_q),
        .gnt  (pick_gnt),
        .idx  (pick_idx)
    );

    // Region add wraps silently at 24 bits.
    function automatic logic [23:0] phys(
        input logic [IW-1:0]     g,
        input logic [CLI_AW-1:0] a
    );
        return region_base(2'(g)) + 24'(a);
    endfunction

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        g_d       = g_q;
        cnt_d     = cnt_q;
        cap_d     = cap_q;
        sd_addr_d = sd_addr_q;
        sd_rd_d   = sd_rd_q;
        ack_d     = ack_q;
        data_d    = data_q;
        unique case (state_q)
            IDLE: begin
                if (|pick_gnt) begin
                    g_d       = pick_idx;
                    cap_d     = addr_arr[pick_idx];
                    sd_addr_d = phys(pick_idx, addr_arr[pick_idx]);
                    sd_rd_d   = 1'b1;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                if (sd_rdy) begin
                    sd_rd_d = 1'b0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (sd_valid) begin
                    if (addr_arr[g_q] == cap_q ||
                        cnt_q == CW'(MAX_REFETCH)) begin
                        data_d[g_q] = sd_data;
                        ack_d[g_q]  = ~ack_q[g_q];
                        rr_d        = (g_q == IW'(NUM_CLIENTS - 1))
                                      ? '0 : g_q + 1'b1;
                        cnt_d       = '0;
                        state_d     = IDLE;
                    end else begin
                        cap_d     = addr_arr[g_q];
                        sd_addr_d = phys(g_q, addr_arr[g_q]);
                        sd_rd_d   = 1'b1;
                        cnt_d     = cnt_q + 1'b1;
                        state_d   = ISSUE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state_q   <= IDLE;
            rr_q      <= '0;
            g_q       <= '0;
            cnt_q     <= '0;
            cap_q     <= '0;
            sd_addr_q <= '0;
            sd_rd_q   <= 1'b0;
            ack_q     <= '0;
            for (int i = 0; i < NUM_CLIENTS; i++) data_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            g_q       <= g_d;
            cnt_q     <= cnt_d;
            cap_q     <= cap_d;
            sd_addr_q <= sd_addr_d;
            sd_rd_q   <= sd_rd_d;
            ack_q     <= ack_d;
            data_q    <= data_d;
        end
    end

    assign cli_ack = ack_q;
    assign sd_addr = sd_addr_q;
    assign sd_rd   = sd_rd_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_gfx_rom_sdram_arbiter.sv
// Scoreboard bench for gfx_rom_sdram_arbiter with a small SDRAM model.
// Stimulus pushes expected reads/acks; one monitor pops and compares.
module tb_gfx_rom_sdram_arbiter;

    localparam int LAT = 5;

    typedef struct packed {
        logic [1:0]  cli;
        logic [15:0] dat;
    } ack_t;

    logic        clk = 1'b0;
    logic        RESET = 1'b1;
    logic [2:0]  req = '0;
    logic [23:0] a0 = '0;
    logic [23:0] a1 = '0;
    logic [23:0] a2 = '0;
    logic [71:0] cli_addr;
    logic [2:0]  cli_ack;
    logic [47:0] cli_data;
    logic [23:0] sd_addr;
    logic        sd_rd;
    logic        sd_rdy = 1'b1;
    logic [15:0] sd_data = '0;
    logic        sd_valid = 1'b0;
    logic        busy;

    int checks = 0;
    int errors = 0;

    ack_t        ackq [$];
    logic [23:0] addrq [$];

    int          n_acc = 0;
    int          lat = 0;
    int          mv_cnt = 0;
    int          mv_limit = 0;
    logic        mv_pend = 1'b0;
    logic        ovr_en = 1'b0;
    logic [15:0] ovr_data = '0;
    logic [23:0] rd_addr = '0;
    logic        prev_stall = 1'b0;
    logic [23:0] prev_addr = '0;
    logic [2:0]  prev_ack = '0;
    logic [2:0]  exp_ack = '0;
    logic [15:0] exp_dat [3];
    logic        finish_req = 1'b0;
    logic        final_done = 1'b0;
    ack_t        e;

    always #5 clk = ~clk;

    assign cli_addr = {a2, a1, a0 + 24'(mv_cnt)};

    gfx_rom_sdram_arbiter dut (
        .clk      (clk),
        .RESET    (RESET),
        .cli_addr (cli_addr),
        .cli_req  (req),
        .cli_ack  (cli_ack),
        .cli_data (cli_data),
        .sd_addr  (sd_addr),
        .sd_rd    (sd_rd),
        .sd_rdy   (sd_rdy),
        .sd_data  (sd_data),
        .sd_valid (sd_valid),
        .busy     (busy)
    );

    task automatic chk(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // SDRAM model, address mover and scoreboard monitor.
    always @(clk) begin
        if (clk) begin
            if (RESET) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("bp_rd_held", 64'(sd_rd), 64'd1);
                    chk("bp_addr_stable", 64'(sd_addr),
                        64'(prev_addr));
                end
                if (sd_rd && sd_rdy) begin
                    n_acc++;
                    lat = LAT;
                    rd_addr = sd_addr;
                    chk("read_expected", 64'(addrq.size() != 0), 64'd1);
                    if (addrq.size() != 0)
                        chk("sd_addr", 64'(sd_addr),
                            64'(addrq.pop_front()));
                    if (mv_cnt < mv_limit) mv_pend = 1'b1;
                end
                prev_stall = sd_rd && !sd_rdy;
                prev_addr  = sd_addr;
            end
        end else begin
            sd_valid = 1'b0;
            if (mv_pend) begin
                mv_cnt++;
                mv_pend = 1'b0;
            end
            if (lat > 0) begin
                lat--;
                if (lat == 0) begin
                    sd_valid = 1'b1;
                    sd_data  = ovr_en ? ovr_data
                                      : (rd_addr[15:0] ^ 16'h5A5A);
                end
            end
            if (RESET) begin
                chk("rst_ack", 64'(cli_ack), 64'd0);
                chk("rst_data", 64'(cli_data), 64'd0);
                chk("rst_busy", 64'(busy), 64'd0);
                chk("rst_sd_rd", 64'(sd_rd), 64'd0);
                chk("rst_sd_addr", 64'(sd_addr), 64'd0);
                exp_ack = '0;
                for (int i = 0; i < 3; i++) exp_dat[i] = '0;
                prev_ack = cli_ack;
            end else begin
                for (int i = 0; i < 3; i++) begin
                    if (cli_ack[i] !== prev_ack[i]) begin
                        chk("ack_expected", 64'(ackq.size() != 0), 64'd1);
                        if (ackq.size() != 0) begin
                            e = ackq.pop_front();
                            chk("ack_client", 64'(i), 64'(e.cli));
                            chk("ack_data", 64'(cli_data[i*16 +: 16]),
                                64'(e.dat));
                            chk("busy_after_ack", 64'(busy), 64'd0);
                            exp_ack[e.cli] = ~exp_ack[e.cli];
                            exp_dat[e.cli] = e.dat;
                        end
                    end
                end
                prev_ack = cli_ack;
                if (finish_req && !final_done) begin
                    chk("leftover_reads", 64'(addrq.size()), 64'd0);
                    chk("leftover_acks", 64'(ackq.size()), 64'd0);
                    chk("final_ack", 64'(cli_ack), 64'(exp_ack));
                    for (int i = 0; i < 3; i++)
                        chk("final_data", 64'(cli_data[i*16 +: 16]),
                            64'(exp_dat[i]));
                    final_done = 1'b1;
                end
            end
        end
    end

    task automatic wait_idle();
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (ackq.size() == 0 && addrq.size() == 0 &&
                !busy && lat == 0) break;
        end
    endtask

    function automatic ack_t mk(input logic [1:0] c,
                                input logic [15:0] d);
        ack_t t;
        t.cli = c;
        t.dat = d;
        return t;
    endfunction

    initial begin
        logic old;
        int   k;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 RESET = 1'b0;

        // single request with a fixed SDRAM word
        @(negedge clk);
        a0 = 24'h001234;
        ovr_en = 1'b1;
        ovr_data = 16'hBEEF;
        addrq.push_back(24'h021234);
        ackq.push_back(mk(2'd0, 16'hBEEF));
        req[0] = ~req[0];
        wait_idle();
        ovr_en = 1'b0;

        // backpressure, plus 24-bit wrap of the region add
        @(negedge clk);
        a2 = 24'hFFFFF0;
        sd_rdy = 1'b0;
        addrq.push_back(24'h03FFF0);
        ackq.push_back(mk(2'd2, 16'hA5AA));
        req[2] = ~req[2];
        repeat (8) @(negedge clk);
        sd_rdy = 1'b1;
        wait_idle();

        // fairness from rr_ptr 0, then client 0 re-toggles
        @(negedge clk);
        a0 = 24'h000100;
        a1 = 24'h000200;
        a2 = 24'h000300;
        addrq.push_back(24'h020100);
        addrq.push_back(24'h030200);
        addrq.push_back(24'h040300);
        ackq.push_back(mk(2'd0, 16'h5B5A));
        ackq.push_back(mk(2'd1, 16'h585A));
        ackq.push_back(mk(2'd2, 16'h595A));
        old = cli_ack[0];
        req = ~req;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (cli_ack[0] !== old) break;
        end
        addrq.push_back(24'h020100);
        ackq.push_back(mk(2'd0, 16'h5B5A));
        req[0] = ~req[0];
        wait_idle();

        // one refetch after the address moves in flight
        @(negedge clk);
        a0 = 24'h000010;
        mv_limit = 1;
        addrq.push_back(24'h020010);
        addrq.push_back(24'h020011);
        ackq.push_back(mk(2'd0, 16'h5A4B));
        req[0] = ~req[0];
        wait_idle();

        // address moves on every fetch: capped at 1 + 3 reads
        @(negedge clk);
        a0 = 24'h0000FF;
        mv_limit = 5;
        addrq.push_back(24'h020100);
        addrq.push_back(24'h020101);
        addrq.push_back(24'h020102);
        addrq.push_back(24'h020103);
        ackq.push_back(mk(2'd0, 16'h5B59));
        req[0] = ~req[0];
        wait_idle();

        // reset while waiting, then a stale sd_valid arrives
        @(negedge clk);
        a1 = 24'h000500;
        addrq.push_back(24'h030500);
        k = n_acc;
        req[1] = ~req[1];
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (n_acc != k) break;
        end
        @(posedge clk);
        #2;
        RESET = 1'b1;
        req = '0;
        repeat (2) @(posedge clk);
        #2 RESET = 1'b0;
        repeat (12) @(negedge clk);

        finish_req = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (final_done) break;
        end
        if (!final_done) begin
            $display("FAIL final_check: monitor did not complete");
            $fatal(1, "monitor stalled");
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
